// File: rtl/l2_cache_read_pkg.sv
// Shared L2 definitions for the L2 read stage: request opcodes, unit codes,
// geometry constants and small request-decoding helpers.
package l2_cache_read_pkg;

  localparam int NUM_CORES          = 4;
  localparam int L2_NUM_SETS        = 256;
  localparam int L2_SET_INDEX_WIDTH = 8;
  localparam int L2_NUM_WAYS        = 4;
  localparam int L2_ADDR_WIDTH      = 26;
  localparam int L2_TAG_WIDTH       = L2_ADDR_WIDTH - L2_SET_INDEX_WIDTH;
  localparam int L2_LINE_WIDTH      = 512;
  localparam int L2_MASK_WIDTH      = 64;

  typedef enum logic [2:0] {
    L2REQ_LOAD       = 3'd0,
    L2REQ_STORE      = 3'd1,
    L2REQ_FLUSH      = 3'd2,
    L2REQ_INVALIDATE = 3'd3,
    L2REQ_LOAD_SYNC  = 3'd4,
    L2REQ_STORE_SYNC = 3'd5
  } l2req_op_e;

  typedef enum logic [1:0] {
    UNIT_ICACHE = 2'd0,
    UNIT_DCACHE = 2'd1,
    UNIT_STBUF  = 2'd2,
    UNIT_IOBUS  = 2'd3
  } unit_e;

  // True for requests that modify the line and therefore may need an L1 refresh.
  function automatic logic is_store_op(input logic [2:0] op);
    return (op == L2REQ_STORE) || (op == L2REQ_STORE_SYNC);
  endfunction

  // True for requests that write a dirty line back to memory.
  function automatic logic is_flush_op(input logic [2:0] op);
    return op == L2REQ_FLUSH;
  endfunction

endpackage

// File: rtl/l2_cache_read_sram.sv
// Simple one-read one-write synchronous SRAM model used as the L2 data store.
// Read data is registered and holds when no read is enabled; the array itself
// has no reset so contents survive a pipeline reset.
module sram_1r1w #(
  parameter int DATA_WIDTH = 512,
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];

  // Array write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[write_addr] <= write_data;
    end
  end

  // Registered read port; the output holds between enabled reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (read_en) begin
      read_data <= mem_q[read_addr];
    end
  end

endmodule

// File: rtl/l2_cache_read.sv
// L2 read stage: reads the data line for hits, flushes and fill victims,
// resolves dirty-writeback and L1-update flags and registers the request for
// the update stage. Same-cycle write/read collisions return the new data.
// Optional performance events are enabled with the macro L2_READ_PERF_EN.
module l2_cache_read
  import l2_cache_read_pkg::*;
#(
  parameter int NUM_SETS  = 256,
  parameter int SET_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_pipeline,
  input  logic                       dir_l2req_valid,
  input  logic [1:0]                 dir_l2req_unit,
  input  logic [1:0]                 dir_l2req_strand,
  input  logic [2:0]                 dir_l2req_op,
  input  logic [1:0]                 dir_l2req_way,
  input  logic [25:0]                dir_l2req_address,
  input  logic [511:0]               dir_l2req_data,
  input  logic [63:0]                dir_l2req_mask,
  input  logic                       dir_has_sm_data,
  input  logic [511:0]               dir_sm_data,
  input  logic [1:0]                 dir_sm_fill_way,
  input  logic [1:0]                 dir_hit_l2_way,
  input  logic [1:0]                 dir_replace_l2_way,
  input  logic                       dir_cache_hit,
  input  logic [L2_TAG_WIDTH-1:0]    dir_old_l2_tag,
  input  logic                       dir_l1_has_line,
  input  logic [NUM_CORES*2-1:0]     dir_l1_way,
  input  logic                       dir_l2_dirty0,
  input  logic                       dir_l2_dirty1,
  input  logic                       dir_l2_dirty2,
  input  logic                       dir_l2_dirty3,
  input  logic                       wr_update_l2_data,
  input  logic [SET_WIDTH-1:0]       wr_update_set,
  input  logic [1:0]                 wr_update_way,
  input  logic [511:0]               wr_update_data,
  output logic                       rd_l2req_valid,
  output logic [1:0]                 rd_l2req_unit,
  output logic [1:0]                 rd_l2req_strand,
  output logic [2:0]                 rd_l2req_op,
  output logic [1:0]                 rd_l2req_way,
  output logic [25:0]                rd_l2req_address,
  output logic [511:0]               rd_l2req_data,
  output logic [63:0]                rd_l2req_mask,
  output logic                       rd_has_sm_data,
  output logic [511:0]               rd_sm_data,
  output logic [1:0]                 rd_sm_fill_way,
  output logic [1:0]                 rd_hit_l2_way,
  output logic [1:0]                 rd_replace_l2_way,
  output logic                       rd_cache_hit,
  output logic [L2_TAG_WIDTH-1:0]    rd_old_l2_tag,
  output logic                       rd_l1_has_line,
  output logic [NUM_CORES*2-1:0]     rd_l1_way,
  output logic [511:0]               rd_cache_mem_result,
  output logic                       rd_dirty_writeback,
  output logic                       rd_update_l1,
  output logic                       pc_event_hit,
  output logic                       pc_event_miss,
  output logic                       pc_event_writeback
);

  logic                   sram_re_s;
  logic [1:0]             read_way_s;
  logic [SET_WIDTH+1:0]   read_addr_s;
  logic [SET_WIDTH+1:0]   write_addr_s;
  logic [3:0]             dirty_s;
  logic                   collide_s;
  logic                   dirty_wb_d;
  logic                   update_l1_d;
  logic [511:0]           sram_rdata_s;
  logic                   collide_q;
  logic [511:0]           fwd_data_q;

  assign sram_re_s    = dir_l2req_valid && !stall_pipeline;
  assign read_way_s   = dir_has_sm_data ? dir_replace_l2_way : dir_hit_l2_way;
  assign read_addr_s  = {read_way_s, dir_l2req_address[SET_WIDTH-1:0]};
  assign write_addr_s = {wr_update_way, wr_update_set};
  assign dirty_s      = {dir_l2_dirty3, dir_l2_dirty2, dir_l2_dirty1, dir_l2_dirty0};
  assign collide_s    = wr_update_l2_data && (write_addr_s == read_addr_s);

  // Writeback and L1-update decisions for the request entering this stage.
  always_comb begin
    dirty_wb_d  = 1'b0;
    update_l1_d = 1'b0;
    if (dir_l2req_valid) begin
      dirty_wb_d  = (dir_has_sm_data && dirty_s[dir_replace_l2_way])
                 || (is_flush_op(dir_l2req_op) && dir_cache_hit && dirty_s[dir_hit_l2_way]);
      update_l1_d = dir_cache_hit && !dir_has_sm_data && is_store_op(dir_l2req_op)
                 && dir_l1_has_line;
    end else begin
      dirty_wb_d  = 1'b0;
      update_l1_d = 1'b0;
    end
  end

  sram_1r1w #(
    .DATA_WIDTH(512),
    .SIZE      (4 * NUM_SETS),
    .ADDR_WIDTH(SET_WIDTH + 2)
  ) u_data_sram (
    .clk       (clk),
    .reset     (reset),
    .read_en   (sram_re_s),
    .read_addr (read_addr_s),
    .read_data (sram_rdata_s),
    .write_en  (wr_update_l2_data),
    .write_addr(write_addr_s),
    .write_data(wr_update_data)
  );

  // Capture write data that collides with the current read so the new line wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collide_q  <= 1'b0;
      fwd_data_q <= '0;
    end else if (sram_re_s) begin
      collide_q <= collide_s;
      if (collide_s) begin
        fwd_data_q <= wr_update_data;
      end
    end
  end

  assign rd_cache_mem_result = collide_q ? fwd_data_q : sram_rdata_s;

  // Stage registers toward the update stage; frozen while the pipeline stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_l2req_valid     <= 1'b0;
      rd_l2req_unit      <= 2'd0;
      rd_l2req_strand    <= 2'd0;
      rd_l2req_op        <= 3'd0;
      rd_l2req_way       <= 2'd0;
      rd_l2req_address   <= 26'd0;
      rd_l2req_data      <= '0;
      rd_l2req_mask      <= 64'd0;
      rd_has_sm_data     <= 1'b0;
      rd_sm_data         <= '0;
      rd_sm_fill_way     <= 2'd0;
      rd_hit_l2_way      <= 2'd0;
      rd_replace_l2_way  <= 2'd0;
      rd_cache_hit       <= 1'b0;
      rd_old_l2_tag      <= '0;
      rd_l1_has_line     <= 1'b0;
      rd_l1_way          <= '0;
      rd_dirty_writeback <= 1'b0;
      rd_update_l1       <= 1'b0;
    end else if (!stall_pipeline) begin
      rd_l2req_valid     <= dir_l2req_valid;
      rd_l2req_unit      <= dir_l2req_unit;
      rd_l2req_strand    <= dir_l2req_strand;
      rd_l2req_op        <= dir_l2req_op;
      rd_l2req_way       <= dir_l2req_way;
      rd_l2req_address   <= dir_l2req_address;
      rd_l2req_data      <= dir_l2req_data;
      rd_l2req_mask      <= dir_l2req_mask;
      rd_has_sm_data     <= dir_has_sm_data;
      rd_sm_data         <= dir_sm_data;
      rd_sm_fill_way     <= dir_sm_fill_way;
      rd_hit_l2_way      <= dir_hit_l2_way;
      rd_replace_l2_way  <= dir_replace_l2_way;
      rd_cache_hit       <= dir_cache_hit;
      rd_old_l2_tag      <= dir_old_l2_tag;
      rd_l1_has_line     <= dir_l1_has_line;
      rd_l1_way          <= dir_l1_way;
      rd_dirty_writeback <= dirty_wb_d;
      rd_update_l1       <= update_l1_d;
    end
  end

`ifdef L2_READ_PERF_EN
  // One-cycle event pulses for valid requests; nothing is pulsed while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_event_hit       <= 1'b0;
      pc_event_miss      <= 1'b0;
      pc_event_writeback <= 1'b0;
    end else if (stall_pipeline) begin
      pc_event_hit       <= 1'b0;
      pc_event_miss      <= 1'b0;
      pc_event_writeback <= 1'b0;
    end else begin
      pc_event_hit       <= dir_l2req_valid && !dir_has_sm_data && dir_cache_hit;
      pc_event_miss      <= dir_l2req_valid && !dir_has_sm_data && !dir_cache_hit;
      pc_event_writeback <= dirty_wb_d;
    end
  end
`else
  assign pc_event_hit       = 1'b0;
  assign pc_event_miss      = 1'b0;
  assign pc_event_writeback = 1'b0;
`endif

endmodule

// File: tb/tb_l2_cache_read.sv
// Self-checking bench for l2_cache_read: directed scenarios plus randomized
// traffic against a behavioural model built on a plain line array.
module tb_l2_cache_read;
  import l2_cache_read_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic stall_pipeline;
  logic dir_l2req_valid;
  logic [1:0] dir_l2req_unit, dir_l2req_strand, dir_l2req_way;
  logic [2:0] dir_l2req_op;
  logic [25:0] dir_l2req_address;
  logic [511:0] dir_l2req_data, dir_sm_data;
  logic [63:0] dir_l2req_mask;
  logic dir_has_sm_data, dir_cache_hit, dir_l1_has_line;
  logic [1:0] dir_sm_fill_way, dir_hit_l2_way, dir_replace_l2_way;
  logic [L2_TAG_WIDTH-1:0] dir_old_l2_tag;
  logic [7:0] dir_l1_way;
  logic dir_l2_dirty0, dir_l2_dirty1, dir_l2_dirty2, dir_l2_dirty3;
  logic wr_update_l2_data;
  logic [7:0] wr_update_set;
  logic [1:0] wr_update_way;
  logic [511:0] wr_update_data;

  logic rd_l2req_valid;
  logic [1:0] rd_l2req_unit, rd_l2req_strand, rd_l2req_way;
  logic [2:0] rd_l2req_op;
  logic [25:0] rd_l2req_address;
  logic [511:0] rd_l2req_data, rd_sm_data, rd_cache_mem_result;
  logic [63:0] rd_l2req_mask;
  logic rd_has_sm_data, rd_cache_hit, rd_l1_has_line;
  logic [1:0] rd_sm_fill_way, rd_hit_l2_way, rd_replace_l2_way;
  logic [L2_TAG_WIDTH-1:0] rd_old_l2_tag;
  logic [7:0] rd_l1_way;
  logic rd_dirty_writeback, rd_update_l1;
  logic pc_event_hit, pc_event_miss, pc_event_writeback;

  l2_cache_read dut (
    .clk(clk), .reset(reset), .stall_pipeline(stall_pipeline),
    .dir_l2req_valid(dir_l2req_valid), .dir_l2req_unit(dir_l2req_unit),
    .dir_l2req_strand(dir_l2req_strand), .dir_l2req_op(dir_l2req_op),
    .dir_l2req_way(dir_l2req_way), .dir_l2req_address(dir_l2req_address),
    .dir_l2req_data(dir_l2req_data), .dir_l2req_mask(dir_l2req_mask),
    .dir_has_sm_data(dir_has_sm_data), .dir_sm_data(dir_sm_data),
    .dir_sm_fill_way(dir_sm_fill_way), .dir_hit_l2_way(dir_hit_l2_way),
    .dir_replace_l2_way(dir_replace_l2_way), .dir_cache_hit(dir_cache_hit),
    .dir_old_l2_tag(dir_old_l2_tag), .dir_l1_has_line(dir_l1_has_line),
    .dir_l1_way(dir_l1_way), .dir_l2_dirty0(dir_l2_dirty0),
    .dir_l2_dirty1(dir_l2_dirty1), .dir_l2_dirty2(dir_l2_dirty2),
    .dir_l2_dirty3(dir_l2_dirty3), .wr_update_l2_data(wr_update_l2_data),
    .wr_update_set(wr_update_set), .wr_update_way(wr_update_way),
    .wr_update_data(wr_update_data),
    .rd_l2req_valid(rd_l2req_valid), .rd_l2req_unit(rd_l2req_unit),
    .rd_l2req_strand(rd_l2req_strand), .rd_l2req_op(rd_l2req_op),
    .rd_l2req_way(rd_l2req_way), .rd_l2req_address(rd_l2req_address),
    .rd_l2req_data(rd_l2req_data), .rd_l2req_mask(rd_l2req_mask),
    .rd_has_sm_data(rd_has_sm_data), .rd_sm_data(rd_sm_data),
    .rd_sm_fill_way(rd_sm_fill_way), .rd_hit_l2_way(rd_hit_l2_way),
    .rd_replace_l2_way(rd_replace_l2_way), .rd_cache_hit(rd_cache_hit),
    .rd_old_l2_tag(rd_old_l2_tag), .rd_l1_has_line(rd_l1_has_line),
    .rd_l1_way(rd_l1_way), .rd_cache_mem_result(rd_cache_mem_result),
    .rd_dirty_writeback(rd_dirty_writeback), .rd_update_l1(rd_update_l1),
    .pc_event_hit(pc_event_hit), .pc_event_miss(pc_event_miss),
    .pc_event_writeback(pc_event_writeback)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: line array indexed by {way,set} and the expected stage outputs.
  logic [511:0] line_m [1024];
  logic e_valid, e_hit, e_sm, e_l1has, e_wb, e_upd, e_pch, e_pcm, e_pcw;
  logic [2:0] e_op;
  logic [25:0] e_addr;
  logic [511:0] e_data, e_smdata, e_result;
  logic [63:0] e_mask;
  logic [1:0] e_unit, e_strand, e_way, e_fill, e_hitway, e_repway;
  logic [L2_TAG_WIDTH-1:0] e_tag;
  logic [7:0] e_l1way;

  logic perf_on;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rnd();
    return $urandom;
  endfunction

  task automatic zero_expect();
    {e_valid, e_hit, e_sm, e_l1has, e_wb, e_upd, e_pch, e_pcm, e_pcw} = 9'd0;
    e_op = 3'd0; e_addr = 26'd0; e_data = '0; e_smdata = '0; e_result = '0;
    e_mask = 64'd0; e_unit = 2'd0; e_strand = 2'd0; e_way = 2'd0; e_fill = 2'd0;
    e_hitway = 2'd0; e_repway = 2'd0; e_tag = '0; e_l1way = 8'd0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [3:0] dirty;
    logic [1:0] rway;
    logic is_store, is_fill;
    dirty = {dir_l2_dirty3, dir_l2_dirty2, dir_l2_dirty1, dir_l2_dirty0};
    rway = dir_has_sm_data ? dir_replace_l2_way : dir_hit_l2_way;
    // The update stage's write lands before the read observes the line.
    if (wr_update_l2_data) line_m[{wr_update_way, wr_update_set}] = wr_update_data;
    if (reset) begin
      zero_expect();
    end else if (stall_pipeline) begin
      {e_pch, e_pcm, e_pcw} = 3'd0;
    end else begin
      is_store = (dir_l2req_op == L2REQ_STORE) || (dir_l2req_op == L2REQ_STORE_SYNC);
      is_fill = dir_has_sm_data;
      e_valid = dir_l2req_valid; e_unit = dir_l2req_unit; e_strand = dir_l2req_strand;
      e_op = dir_l2req_op; e_way = dir_l2req_way; e_addr = dir_l2req_address;
      e_data = dir_l2req_data; e_mask = dir_l2req_mask; e_sm = dir_has_sm_data;
      e_smdata = dir_sm_data; e_fill = dir_sm_fill_way; e_hitway = dir_hit_l2_way;
      e_repway = dir_replace_l2_way; e_hit = dir_cache_hit; e_tag = dir_old_l2_tag;
      e_l1has = dir_l1_has_line; e_l1way = dir_l1_way;
      if (dir_l2req_valid) e_result = line_m[{rway, dir_l2req_address[7:0]}];
      e_wb = dir_l2req_valid && ((is_fill && dirty[dir_replace_l2_way]) ||
             (dir_l2req_op == L2REQ_FLUSH && dir_cache_hit && dirty[dir_hit_l2_way]));
      e_upd = dir_l2req_valid && dir_cache_hit && !is_fill && is_store && dir_l1_has_line;
      e_pch = perf_on && dir_l2req_valid && !is_fill && dir_cache_hit;
      e_pcm = perf_on && dir_l2req_valid && !is_fill && !dir_cache_hit;
      e_pcw = perf_on && e_wb;
    end
  endtask

  task automatic check_all();
    check_eq("valid", 512'(rd_l2req_valid), 512'(e_valid));
    check_eq("unit", 512'(rd_l2req_unit), 512'(e_unit));
    check_eq("strand", 512'(rd_l2req_strand), 512'(e_strand));
    check_eq("op", 512'(rd_l2req_op), 512'(e_op));
    check_eq("way", 512'(rd_l2req_way), 512'(e_way));
    check_eq("address", 512'(rd_l2req_address), 512'(e_addr));
    check_eq("data", rd_l2req_data, e_data);
    check_eq("mask", 512'(rd_l2req_mask), 512'(e_mask));
    check_eq("has_sm", 512'(rd_has_sm_data), 512'(e_sm));
    check_eq("sm_data", rd_sm_data, e_smdata);
    check_eq("fill_way", 512'(rd_sm_fill_way), 512'(e_fill));
    check_eq("hit_way", 512'(rd_hit_l2_way), 512'(e_hitway));
    check_eq("rep_way", 512'(rd_replace_l2_way), 512'(e_repway));
    check_eq("cache_hit", 512'(rd_cache_hit), 512'(e_hit));
    check_eq("old_tag", 512'(rd_old_l2_tag), 512'(e_tag));
    check_eq("l1_has", 512'(rd_l1_has_line), 512'(e_l1has));
    check_eq("l1_way", 512'(rd_l1_way), 512'(e_l1way));
    check_eq("mem_result", rd_cache_mem_result, e_result);
    check_eq("dirty_wb", 512'(rd_dirty_writeback), 512'(e_wb));
    check_eq("update_l1", 512'(rd_update_l1), 512'(e_upd));
    check_eq("pc_hit", 512'(pc_event_hit), 512'(e_pch));
    check_eq("pc_miss", 512'(pc_event_miss), 512'(e_pcm));
    check_eq("pc_wb", 512'(pc_event_writeback), 512'(e_pcw));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive_idle();
    stall_pipeline = 1'b0; dir_l2req_valid = 1'b0; wr_update_l2_data = 1'b0;
    dir_has_sm_data = 1'b0; dir_cache_hit = 1'b0; dir_l1_has_line = 1'b0;
    {dir_l2_dirty3, dir_l2_dirty2, dir_l2_dirty1, dir_l2_dirty0} = 4'd0;
  endtask

  // Randomize every request field; callers override what a scenario needs.
  task automatic rand_request();
    logic [31:0] r;
    r = rnd();
    dir_l2req_valid = 1'b1; dir_l2req_unit = r[1:0]; dir_l2req_strand = r[3:2];
    dir_l2req_op = 3'(r[6:4] % 3'd6); dir_l2req_way = r[8:7];
    dir_has_sm_data = r[9]; dir_sm_fill_way = r[11:10]; dir_hit_l2_way = r[13:12];
    dir_replace_l2_way = r[15:14]; dir_cache_hit = r[16]; dir_l1_has_line = r[17];
    {dir_l2_dirty3, dir_l2_dirty2, dir_l2_dirty1, dir_l2_dirty0} = r[21:18];
    dir_l1_way = r[29:22];
    r = rnd(); dir_l2req_address = r[25:0];
    r = rnd(); dir_old_l2_tag = r[L2_TAG_WIDTH-1:0];
    dir_l2req_mask = {rnd(), rnd()};
    dir_l2req_data = rand_line(); dir_sm_data = rand_line();
  endtask

  logic [511:0] line_a, line_b, saved;
  logic [31:0] r;

  initial begin
`ifdef L2_READ_PERF_EN
    perf_on = 1'b1;
`else
    perf_on = 1'b0;
`endif
    zero_expect();
    rand_request();
    drive_idle();
    reset = 1'b1;
    wr_update_set = 8'd0; wr_update_way = 2'd0; wr_update_data = '0;
    #2;
    // Reset state.
    check_all();
    cycle();
    @(negedge clk);
    reset = 1'b0;

    // Preload every line so reads compare against known data.
    for (int a = 0; a < 1024; a++) begin
      wr_update_l2_data = 1'b1;
      wr_update_way = 2'(a >> 8); wr_update_set = 8'(a);
      wr_update_data = rand_line();
      cycle();
    end
    drive_idle();

    // Scenario 1: write way2 set5, then load-hit it.
    line_a = rand_line();
    wr_update_l2_data = 1'b1; wr_update_way = 2'd2; wr_update_set = 8'd5;
    wr_update_data = line_a;
    cycle();
    rand_request();
    wr_update_l2_data = 1'b0;
    dir_l2req_op = L2REQ_LOAD; dir_has_sm_data = 1'b0; dir_cache_hit = 1'b1;
    dir_hit_l2_way = 2'd2; dir_l2req_address[7:0] = 8'd5;
    cycle();
    check_eq("t1_result", rd_cache_mem_result, line_a);
    check_eq("t1_hit", 512'(rd_cache_hit), 512'(1'b1));
    check_eq("t1_pc_hit", 512'(pc_event_hit), 512'(perf_on));

    // Scenario 2: fill whose victim way1 is dirty.
    rand_request();
    dir_has_sm_data = 1'b1; dir_replace_l2_way = 2'd1; dir_l2_dirty1 = 1'b1;
    dir_l2req_address[7:0] = 8'd77;
    saved = line_m[{2'd1, 8'd77}];
    cycle();
    check_eq("t2_wb", 512'(rd_dirty_writeback), 512'(1'b1));
    check_eq("t2_victim", rd_cache_mem_result, saved);

    // Scenario 3: store hit with and without an L1 copy.
    rand_request();
    dir_l2req_op = L2REQ_STORE; dir_has_sm_data = 1'b0; dir_cache_hit = 1'b1;
    dir_l1_has_line = 1'b1; dir_l1_way = 8'd3;
    cycle();
    check_eq("t3_upd", 512'(rd_update_l1), 512'(1'b1));
    check_eq("t3_l1way", 512'(rd_l1_way), 512'(8'd3));
    dir_l1_has_line = 1'b0;
    cycle();
    check_eq("t3_noupd", 512'(rd_update_l1), 512'(1'b0));

    // Scenario 4: same-cycle write and read of set9 way0.
    line_b = rand_line();
    rand_request();
    dir_has_sm_data = 1'b0; dir_hit_l2_way = 2'd0; dir_l2req_address[7:0] = 8'd9;
    wr_update_l2_data = 1'b1; wr_update_way = 2'd0; wr_update_set = 8'd9;
    wr_update_data = line_b;
    cycle();
    check_eq("t4_fwd", rd_cache_mem_result, line_b);
    wr_update_l2_data = 1'b0;

    // Scenario 5: three stalled cycles with changing inputs, then release.
    rand_request();
    cycle();
    saved = rd_cache_mem_result;
    for (int s = 0; s < 3; s++) begin
      rand_request();
      stall_pipeline = 1'b1;
      cycle();
      check_eq("t5_hold", rd_cache_mem_result, e_result);
    end
    stall_pipeline = 1'b0;
    cycle();

    // Randomized traffic with stalls and frequent read/write collisions.
    for (int n = 0; n < 600; n++) begin
      rand_request();
      r = rnd();
      dir_l2req_valid = (r[1:0] != 2'd0);
      stall_pipeline = (r[4:2] == 3'd0);
      wr_update_l2_data = r[5];
      if (r[7:6] == 2'd0) begin
        wr_update_set = dir_l2req_address[7:0];
        wr_update_way = dir_has_sm_data ? dir_replace_l2_way : dir_hit_l2_way;
      end else begin
        wr_update_set = r[15:8]; wr_update_way = r[17:16];
      end
      wr_update_data = rand_line();
      cycle();
    end

    // Scenario 6: reset arrives with a valid request outstanding.
    drive_idle();
    saved = line_m[{2'd2, 8'd5}];
    rand_request();
    dir_has_sm_data = 1'b0;
    #2;
    reset = 1'b1;
    zero_expect();
    #1;
    check_eq("t6_valid", 512'(rd_l2req_valid), 512'(1'b0));
    check_eq("t6_result", rd_cache_mem_result, 512'd0);
    cycle();
    @(negedge clk);
    reset = 1'b0;
    rand_request();
    dir_has_sm_data = 1'b0; dir_hit_l2_way = 2'd2; dir_l2req_address[7:0] = 8'd5;
    cycle();
    check_eq("t6_retained", rd_cache_mem_result, saved);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
